// File: rtl/aes_pkg.sv
// Shared AES datapath definitions.
// Holds the block geometry and the ShiftRows / InvShiftRows byte-index
// tables so the encryption and decryption stages use one definition, plus
// the occupancy encoding of the inverse-ShiftRows output queue.
//
// Byte layout: byte k = row + 4*col. Byte 0 is the most significant byte of
// a 128-bit vector, i.e. the leftmost byte of a FIPS-197 hex string.
package aes_pkg;

  localparam int unsigned AES_BLOCK_W = 128;
  localparam int unsigned AES_NB      = 4;
  localparam int unsigned AES_BYTES   = AES_NB * AES_NB;

  // Encryption: out byte k takes in byte SHIFT_IDX[k] (row r rotates left r).
  localparam int unsigned SHIFT_IDX [AES_BYTES] = '{
    0, 5, 10, 15, 4, 9, 14, 3, 8, 13, 2, 7, 12, 1, 6, 11
  };

  // Decryption: out byte k takes in byte INV_SHIFT_IDX[k] (row r rotates right r).
  localparam int unsigned INV_SHIFT_IDX [AES_BYTES] = '{
    0, 13, 10, 7, 4, 1, 14, 11, 8, 5, 2, 15, 12, 9, 6, 3
  };

  // Occupancy of the 2-entry output queue.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_state_e;

endpackage

// File: rtl/inv_shift_rows_perm.sv
// Combinational InvShiftRows byte permutation.
// Ports:
//   state_i  AES state in  (byte 0 = most significant byte)
//   state_o  AES state with row r rotated right by r
module inv_shift_rows_perm
  import aes_pkg::*;
(
  input  logic [AES_BLOCK_W-1:0] state_i,
  output logic [AES_BLOCK_W-1:0] state_o
);

  for (genvar k = 0; k < AES_BYTES; k++) begin : g_byte
    localparam int unsigned SRC = INV_SHIFT_IDX[k];
    // Byte k occupies the k-th byte counting down from the MSB.
    assign state_o[AES_BLOCK_W-1-8*k -: 8] = state_i[AES_BLOCK_W-1-8*SRC -: 8];
  end

endmodule

// File: rtl/inv_shift_rows.sv
// Inverse ShiftRows stage with a 2-entry output queue.
// Ports:
//   clk, reset           clock; asynchronous active-low reset
//   in_valid/in_ready    input handshake, Data is the 128-bit state
//   out_valid/out_ready  output handshake, Shifted_Data is the queue head
//   done                 high the cycle after each accepted input
//   blk_count            number of output transfers, wraps modulo 2^COUNT_W
//   occ_state            queue occupancy (debug visibility)
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. in_ready and out_valid are decoded from the registered
// occupancy only, so neither has a combinational path from the other side.
module inv_shift_rows
  import aes_pkg::*;
#(
  parameter int unsigned COUNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_BLOCK_W-1:0] Data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_BLOCK_W-1:0] Shifted_Data,
  output logic                   done,
  output logic [COUNT_W-1:0]     blk_count,
  output occ_state_e             occ_state
);

  occ_state_e               state_q, state_d;
  logic [AES_BLOCK_W-1:0]   head_q, head_d;
  logic [AES_BLOCK_W-1:0]   tail_q, tail_d;
  logic                     done_q;
  logic [COUNT_W-1:0]       cnt_q, cnt_d;
  logic [AES_BLOCK_W-1:0]   perm_data;
  logic                     push, pop;

  inv_shift_rows_perm u_perm (
    .state_i (Data),
    .state_o (perm_data)
  );

  assign in_ready  = (state_q != OCC_FULL);
  assign out_valid = (state_q != OCC_EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // head_q is always the oldest entry; tail_q is only meaningful when FULL.
  // On pop to EMPTY head_q is left untouched so the output keeps the last value.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      OCC_EMPTY: begin
        if (push) begin
          head_d  = perm_data;
          state_d = OCC_ONE;
        end
      end
      OCC_ONE: begin
        if (push && pop) begin
          head_d = perm_data;
        end else if (push) begin
          tail_d  = perm_data;
          state_d = OCC_FULL;
        end else if (pop) begin
          state_d = OCC_EMPTY;
        end
      end
      OCC_FULL: begin
        if (pop) begin
          head_d  = tail_q;
          state_d = OCC_ONE;
        end
      end
      default: state_d = OCC_EMPTY;
    endcase
  end

  assign cnt_d = pop ? cnt_q + COUNT_W'(1) : cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= OCC_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      done_q  <= push;
      cnt_q   <= cnt_d;
    end
  end

  assign Shifted_Data = head_q;
  assign done         = done_q;
  assign blk_count    = cnt_q;
  assign occ_state    = state_q;

endmodule
